// File: rtl/chacha_pkg.sv
// Shared types, command/status bit positions and helpers for the ChaCha block core.
package chacha_pkg;

  localparam int ROUNDS_DEFAULT = 20;

  // uio_in command strobe bit positions
  localparam int WR      = 0;
  localparam int RD      = 1;
  localparam int START   = 2;
  localparam int PTR_CLR = 3;

  // uio_out status bit positions
  localparam int BUSY = 7;
  localparam int DONE = 6;

  typedef logic [31:0] word_t;
  typedef word_t [15:0] state_t;

  function automatic word_t rotl(word_t x, int n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_quarter_round.sv
// Combinational ChaCha quarter round on four 32-bit words.
module chacha_quarter_round
  import chacha_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t a_next,
  output word_t b_next,
  output word_t c_next,
  output word_t d_next
);

  word_t a1, b1, c1, d1, a2, b2, c2, d2;

  assign a1 = a + b;
  assign d1 = rotl(d ^ a1, 16);
  assign c1 = c + d1;
  assign b1 = rotl(b ^ c1, 12);
  assign a2 = a1 + b1;
  assign d2 = rotl(d1 ^ a2, 8);
  assign c2 = c1 + d2;
  assign b2 = rotl(b1 ^ c2, 7);

  assign a_next = a2;
  assign b_next = b2;
  assign c_next = c2;
  assign d_next = d2;

endmodule

// File: rtl/couchand_chacha_block.sv
// ChaCha block function with byte-serial load/unload; one half double-round per cycle.
module couchand_chacha_block
  import chacha_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int            RW   = $clog2(ROUNDS + 1);
  localparam logic [RW-1:0] LAST = RW'(ROUNDS);

  state_t        in_state, work;
  state_t        col_next, diag_next, round_next;
  word_t [3:0]   qa, qb, qc, qd, na, nb, nc, nd;
  logic [5:0]    ptr;
  logic [RW-1:0] rnd;
  logic          busy, done, diag;
  logic          unused_bits;

  assign unused_bits = ^uio_in[7:4];

  // Even round counts run columns, odd ones diagonals.
  assign diag = rnd[0];

  // Four quarter-round lanes; lane g always owns word g as 'a', the other
  // operands rotate by g+1/g+2/g+3 within their row on diagonal cycles.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam int BD = 4  + ((g + 1) % 4);
    localparam int CD = 8  + ((g + 2) % 4);
    localparam int DD = 12 + ((g + 3) % 4);

    assign qa[g] = work[g];
    assign qb[g] = diag ? work[BD] : work[4 + g];
    assign qc[g] = diag ? work[CD] : work[8 + g];
    assign qd[g] = diag ? work[DD] : work[12 + g];

    chacha_quarter_round u_qr (
      .a(qa[g]), .b(qb[g]), .c(qc[g]), .d(qd[g]),
      .a_next(na[g]), .b_next(nb[g]), .c_next(nc[g]), .d_next(nd[g])
    );

    assign col_next[g]       = na[g];
    assign col_next[4 + g]   = nb[g];
    assign col_next[8 + g]   = nc[g];
    assign col_next[12 + g]  = nd[g];
    assign diag_next[g]      = na[g];
    assign diag_next[BD]     = nb[g];
    assign diag_next[CD]     = nc[g];
    assign diag_next[DD]     = nd[g];
  end

  assign round_next = diag ? diag_next : col_next;

  assign uo_out  = work[ptr[5:2]][{ptr[1:0], 3'b000} +: 8];
  assign uio_out = {busy, done, 6'b0};
  assign uio_oe  = 8'b1100_0000;

  // Host command decode when idle; round sequencing and final feed-forward when busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state <= '0;
      work     <= '0;
      ptr      <= '0;
      rnd      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (busy) begin
      if (rnd == LAST) begin
        for (int i = 0; i < 16; i++) work[i] <= work[i] + in_state[i];
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        work <= round_next;
        rnd  <= rnd + 1'b1;
      end
    end else if (ena) begin
      if (uio_in[PTR_CLR]) begin
        ptr <= '0;
      end else if (uio_in[START]) begin
        work <= in_state;
        busy <= 1'b1;
        done <= 1'b0;
        rnd  <= '0;
      end else if (uio_in[WR]) begin
        in_state[ptr[5:2]][{ptr[1:0], 3'b000} +: 8] <= ui_in;
        ptr <= ptr + 1'b1;
      end else if (uio_in[RD]) begin
        ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_couchand_chacha_block.sv
// Scoreboard bench for the ChaCha block core: expected bytes come from a reference model.
module tb_couchand_chacha_block;

  typedef logic [15:0][31:0] blk_t;

  localparam logic [7:0] C_WR = 8'h01;
  localparam logic [7:0] C_RD = 8'h02;
  localparam logic [7:0] C_ST = 8'h04;
  localparam logic [7:0] C_PC = 8'h08;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got[64];
  blk_t       shadow;

  couchand_chacha_block dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r16(logic [31:0] v); return {v[15:0], v[31:16]}; endfunction
  function automatic logic [31:0] r12(logic [31:0] v); return {v[19:0], v[31:20]}; endfunction
  function automatic logic [31:0] r8 (logic [31:0] v); return {v[23:0], v[31:24]}; endfunction
  function automatic logic [31:0] r7 (logic [31:0] v); return {v[24:0], v[31:25]}; endfunction

  function automatic blk_t qr(blk_t x, int a, int b, int c, int d);
    x[a] = x[a] + x[b]; x[d] = r16(x[d] ^ x[a]);
    x[c] = x[c] + x[d]; x[b] = r12(x[b] ^ x[c]);
    x[a] = x[a] + x[b]; x[d] = r8(x[d] ^ x[a]);
    x[c] = x[c] + x[d]; x[b] = r7(x[b] ^ x[c]);
    return x;
  endfunction

  function automatic blk_t block_fn(blk_t s);
    blk_t x;
    x = s;
    for (int r = 0; r < 10; r++) begin
      x = qr(x, 0, 4, 8, 12);  x = qr(x, 1, 5, 9, 13);
      x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
      x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12);
      x = qr(x, 2, 7, 8, 13);  x = qr(x, 3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) x[i] = x[i] + s[i];
    return x;
  endfunction

  function automatic logic [7:0] byte_of(blk_t s, int k);
    logic [511:0] f;
    f = s;
    return f[k*8 +: 8];
  endfunction

  task automatic cyc(input logic [7:0] c, input logic [7:0] d);
    uio_in = c;
    ui_in  = d;
    @(negedge clk);
    uio_in = 8'h00;
  endtask

  task automatic load(input blk_t s);
    cyc(C_PC, 8'h00);
    for (int k = 0; k < 64; k++) cyc(C_WR, byte_of(s, k));
    shadow = s;
  endtask

  task automatic push_block(input blk_t s, input int from, input int n);
    blk_t r;
    r = block_fn(s);
    for (int k = from; k < from + n; k++) exp_q.push_back(byte_of(r, k));
  endtask

  task automatic read_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      got[i] = uo_out;
      cyc(C_RD, 8'h00);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (uio_out[7] === 1'b1 && n < 200) begin
      n++;
      cyc(8'h00, 8'h00);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL reset_uo_out: got %h want 00", uo_out); end
    total++; if (uio_out !== 8'h00) begin bad++; $display("FAIL reset_uio_out: got %h want 00", uio_out); end
    total++; if (uio_oe !== 8'hC0) begin bad++; $display("FAIL reset_uio_oe: got %h want c0", uio_oe); end
    rst_n = 1'b1;
    shadow = '0;
    cyc(C_PC, 8'h00);
    for (int k = 0; k < 64; k++) exp_q.push_back(8'h00);
    read_bytes(64);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] e;
      e = 8'hxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      total++;
      if (got[i] !== e) begin bad++; $display("FAIL reset_sweep[%0d]: got %h want %h", i, got[i], e); end
    end
  endtask

  task automatic test_zero;
    int n;
    cyc(C_ST, 8'h00);
    wait_idle(n);
    total++; if (n !== 21) begin bad++; $display("FAIL zero_busy_cycles: got %0d want 21", n); end
    total++; if (uio_out !== 8'h40) begin bad++; $display("FAIL zero_status: got %h want 40", uio_out); end
    push_block(shadow, 0, 64);
    cyc(C_PC, 8'h00);
    read_bytes(64);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] e;
      e = 8'hxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      total++;
      if (got[i] !== e || got[i] !== 8'h00) begin bad++; $display("FAIL zero_byte[%0d]: got %h want %h", i, got[i], e); end
    end
  endtask

  task automatic test_rfc;
    blk_t s;
    int   n;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int w = 0; w < 8; w++)
      s[4+w] = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
    s[12] = 32'h00000001; s[13] = 32'h09000000; s[14] = 32'h4a000000; s[15] = 32'h00000000;
    load(s);
    cyc(C_ST, 8'h00);
    wait_idle(n);
    total++; if (n !== 21) begin bad++; $display("FAIL rfc_busy_cycles: got %0d want 21", n); end
    total++; if (uio_out[6] !== 1'b1) begin bad++; $display("FAIL rfc_done: got %b want 1", uio_out[6]); end
    push_block(shadow, 0, 64);
    cyc(C_PC, 8'h00);
    read_bytes(64);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] e;
      e = 8'hxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      total++;
      if (got[i] !== e) begin bad++; $display("FAIL rfc_byte[%0d]: got %h want %h", i, got[i], e); end
    end
    total++;
    if ({got[0], got[1], got[2], got[3]} !== 32'h10f1e7e4) begin
      bad++; $display("FAIL rfc_bytes0_3: got %h%h%h%h want 10f1e7e4", got[0], got[1], got[2], got[3]);
    end
    total++;
    if ({got[63], got[62], got[61], got[60]} !== 32'h4e3c50a2) begin
      bad++; $display("FAIL rfc_word15: got %h%h%h%h want 4e3c50a2", got[63], got[62], got[61], got[60]);
    end
  endtask

  task automatic test_wrap;
    logic [511:0] f;
    logic [7:0]   d;
    int           n;
    f = shadow;
    cyc(C_PC, 8'h00);
    for (int k = 0; k < 65; k++) begin
      d = 8'(k * 37 + 11);
      cyc(C_WR, d);
      f[(k % 64)*8 +: 8] = d;
    end
    shadow = f;
    cyc(C_ST, 8'h00);
    wait_idle(n);
    total++; if (n !== 21) begin bad++; $display("FAIL wrap_busy_cycles: got %0d want 21", n); end
    push_block(shadow, 1, 63);
    read_bytes(63);
    for (int i = 0; i < 63; i++) begin
      logic [7:0] e;
      e = 8'hxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      total++;
      if (got[i] !== e) begin bad++; $display("FAIL wrap_byte[%0d]: got %h want %h", i + 1, got[i], e); end
    end
  endtask

  task automatic test_busy_lock;
    int n;
    cyc(C_PC, 8'h00);
    repeat (5) cyc(C_RD, 8'h00);
    cyc(C_ST, 8'h00);
    cyc(C_WR, 8'hAA);
    cyc(C_RD, 8'h00);
    cyc(C_PC, 8'h00);
    cyc(C_ST, 8'h00);
    cyc(8'h0F, 8'h55);
    wait_idle(n);
    total++; if (n + 5 !== 21) begin bad++; $display("FAIL lock_busy_cycles: got %0d want 21", n + 5); end
    total++; if (uio_out !== 8'h40) begin bad++; $display("FAIL lock_status: got %h want 40", uio_out); end
    push_block(shadow, 5, 59);
    read_bytes(59);
    for (int i = 0; i < 59; i++) begin
      logic [7:0] e;
      e = 8'hxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      total++;
      if (got[i] !== e) begin bad++; $display("FAIL lock_byte[%0d]: got %h want %h", i + 5, got[i], e); end
    end
    // start together with wr: only start runs, so state and pointer stay put
    cyc(C_PC, 8'h00);
    cyc(C_ST | C_WR, 8'h5A);
    wait_idle(n);
    total++; if (n !== 21) begin bad++; $display("FAIL startwr_busy_cycles: got %0d want 21", n); end
    push_block(shadow, 0, 64);
    read_bytes(64);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] e;
      e = 8'hxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      total++;
      if (got[i] !== e) begin bad++; $display("FAIL startwr_byte[%0d]: got %h want %h", i, got[i], e); end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    cyc(C_ST, 8'h00);
    repeat (9) cyc(8'h00, 8'h00);
    total++; if (uio_out[7] !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", uio_out[7]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (uio_out !== 8'h00) begin bad++; $display("FAIL mid_status: got %h want 00", uio_out); end
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL mid_uo_out: got %h want 00", uo_out); end
    @(negedge clk);
    rst_n = 1'b1;
    shadow = '0;
    ena = 1'b0;
    cyc(C_WR, 8'hFF);
    cyc(C_RD, 8'h00);
    cyc(C_ST, 8'h00);
    cyc(8'h00, 8'h00);
    total++; if (uio_out !== 8'h00) begin bad++; $display("FAIL ena_low_status: got %h want 00", uio_out); end
    ena = 1'b1;
    cyc(C_ST, 8'h00);
    wait_idle(n);
    total++; if (n !== 21) begin bad++; $display("FAIL ena_busy_cycles: got %0d want 21", n); end
    push_block(shadow, 0, 64);
    read_bytes(64);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] e;
      e = 8'hxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      total++;
      if (got[i] !== e) begin bad++; $display("FAIL ena_byte[%0d]: got %h want %h", i, got[i], e); end
    end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_rfc;
    test_wrap;
    test_busy_lock;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
